// File: rtl/sc_mac_ctrl.sv
// Deterministic stochastic-computing MAC sequencer: clock-division unary streams
// from one 2W-bit counter, AND-ed and counted into a saturating accumulator.
module sc_mac_ctrl #(
  parameter  int W       = 7,
  parameter  int ACC_EXT = 4,
  localparam int ACC_W   = 2 * W + ACC_EXT,
  localparam int CW      = 2 * W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf,
  output logic             busy,
  output logic             bit_a,
  output logic             bit_b
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             last_q, last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             bit_a_q, bit_a_d;
  logic             bit_b_q, bit_b_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    last_d  = last_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          last_d  = in_last;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Increment uses the bits registered alongside the current cnt value.
        if (bit_a_q && bit_b_q) begin
          if (&acc_q) begin
            ovf_d = 1'b1;
          end else begin
            acc_d = acc_q + {{(ACC_W-1){1'b0}}, 1'b1};
          end
        end else begin
          acc_d = acc_q;
        end
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (&cnt_q) begin
          state_d = last_q ? DONE : IDLE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = {ACC_W{1'b0}};
          ovf_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Low half of cnt drives stream A, high half stream B (clock-division ordering).
    bit_a_d     = (state_d == RUN) && (a_d > cnt_d[W-1:0]);
    bit_b_d     = (state_d == RUN) && (b_d > cnt_d[CW-1:W]);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == RUN);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      last_q      <= 1'b0;
      acc_q       <= {ACC_W{1'b0}};
      ovf_q       <= 1'b0;
      bit_a_q     <= 1'b0;
      bit_b_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      bit_a_q     <= bit_a_d;
      bit_b_q     <= bit_b_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = acc_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;
  assign bit_a     = bit_a_q;
  assign bit_b     = bit_b_q;

endmodule

// File: tb/tb_sc_mac_ctrl.sv
// Scoreboard bench for sc_mac_ctrl at W=3, ACC_EXT=0 (6-bit accumulator, max 63).
module tb_sc_mac_ctrl;
  localparam int W     = 3;
  localparam int ACC_W = 6;
  localparam int RUN_CYCLES = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             ovf;
  logic             busy;
  logic             bit_a;
  logic             bit_b;

  int n_vec  = 0;
  int n_fail = 0;

  // Expected {result, ovf} per accumulation, in completion order.
  int exp_res_q[$];
  int exp_ovf_q[$];
  int model_acc = 0;
  int model_ovf = 0;

  sc_mac_ctrl #(.W(W), .ACC_EXT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .ovf(ovf), .busy(busy),
    .bit_a(bit_a), .bit_b(bit_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every result handshake against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_res_q.size() == 0) begin
        chk("unexpected_result", int'(result), -1);
      end else begin
        chk("result", int'(result), exp_res_q.pop_front());
        chk("ovf", int'(ovf), exp_ovf_q.pop_front());
      end
    end
  end

  task automatic model_add(input int av, input int bv, input logic last_i);
    model_acc += av * bv;
    if (model_acc > 63) begin
      model_acc = 63;
      model_ovf = 1;
    end
    if (last_i) begin
      exp_res_q.push_back(model_acc);
      exp_ovf_q.push_back(model_ovf);
      model_acc = 0;
      model_ovf = 0;
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 300) begin
      tick();
      t++;
    end
    chk("wait_in_ready", int'(in_ready), 1);
  endtask

  // Issue one pair and follow it through RUN, checking length and stream overlap.
  task automatic run_pair(input int av, input int bv, input logic last_i);
    int busy_n = 0;
    int ones   = 0;
    wait_ready();
    model_add(av, bv, last_i);
    in_valid = 1'b1;
    a        = W'(av);
    b        = W'(bv);
    in_last  = last_i;
    tick();
    in_valid = 1'b0;
    while (busy && busy_n < 200) begin
      chk("in_ready_low_in_run", int'(in_ready), 0);
      ones += int'(bit_a & bit_b);
      busy_n++;
      tick();
    end
    chk("busy_cycles", busy_n, RUN_CYCLES);
    chk("stream_ones", ones, av * bv);
    chk("in_ready_after_run", int'(in_ready), last_i ? 0 : 1);
    chk("out_valid_after_run", int'(out_valid), last_i ? 1 : 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_bits"}, int'({bit_a, bit_b}), 0);
  endtask

  initial begin
    int t;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_reset_outputs("idle");
    end

    // Single pair 5*3
    run_pair(5, 3, 1'b1);
    tick();
    chk("in_ready_after_result", int'(in_ready), 1);
    chk("out_valid_drop", int'(out_valid), 0);

    // Chained pairs 49 + 12 + 0 = 61
    run_pair(7, 7, 1'b0);
    run_pair(2, 6, 1'b0);
    run_pair(0, 5, 1'b1);
    tick();

    // Saturation then clean accumulation
    run_pair(7, 7, 1'b0);
    run_pair(7, 7, 1'b1);
    tick();
    run_pair(1, 1, 1'b1);
    tick();

    // Backpressure on the result
    out_ready = 1'b0;
    run_pair(4, 4, 1'b1);
    for (int i = 0; i < 20; i++) begin
      chk("hold_result", int'(result), 16);
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pulse_out_valid_drop", int'(out_valid), 0);
    chk("pulse_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;

    // Reset in the middle of RUN aborts with no output
    wait_ready();
    in_valid = 1'b1;
    a        = 3'd7;
    b        = 3'd7;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (29) tick();
    chk("mid_run_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("abort");
    run_pair(3, 3, 1'b1);
    tick();

    t = 0;
    while (exp_res_q.size() != 0 && t < 300) begin
      tick();
      t++;
    end
    chk("scoreboard_drained", exp_res_q.size(), 0);
    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
